// File: rtl/int_div_core.sv
// int_div_core: sequential restoring unsigned divider, one quotient bit per clock.
module int_div_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] d_q, q_q, q_d, r_q, r_d;
  logic [CW-1:0]    cnt_q;
  logic             dz_q;
  logic [WIDTH:0]   sh, t;
  // The partial remainder stays below the divisor, so its top bit is always zero and is not stored.
  always_comb begin
    sh  = {r_q, q_q[WIDTH-1]};
    t   = sh - {1'b0, d_q};
    r_d = t[WIDTH] ? sh[WIDTH-1:0] : t[WIDTH-1:0];
    q_d = {q_q[WIDTH-2:0], ~t[WIDTH]};
  end
  assign busy = state_q == RUN;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      d_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      dz_q        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          d_q     <= divisor;
          q_q     <= dividend;
          r_q     <= '0;
          cnt_q   <= CW'(WIDTH);
          dz_q    <= divisor == '0;
          state_q <= RUN;
        end
      end else begin
        r_q   <= r_d;
        q_q   <= q_d;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          quotient    <= q_d;
          remainder   <= r_d;
          div_by_zero <= dz_q;
          done        <= 1'b1;
          state_q     <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_int_div_core.sv
// tb_int_div_core: scoreboard bench; stimulus pushes expected {q,r,dz}, a monitor pops on done.
module tb_int_div_core;
  logic       clk, rst, start, busy, done, div_by_zero;
  logic [3:0] dividend, divisor, quotient, remainder;
  logic [8:0] exp_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc;

  int_div_core #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b);
    return (b == 0) ? {4'd15, a, 1'b1} : {4'(a / b), 4'(a % b), 1'b0};
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got q=%0d r=%0d dz=%0b with nothing expected at %0t",
                 quotient, remainder, div_by_zero, $time);
      end else begin
        check("result", {quotient, remainder, div_by_zero}, exp_q.pop_front());
      end
    end
  end

  task automatic launch(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    start = 1;
    dividend = a;
    divisor = b;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, required one", n);
    end
  endtask

  task automatic run(input logic [3:0] a, input logic [3:0] b, input logic [8:0] e);
    exp_q.push_back(e);
    launch(a, b);
    wait_done(cyc);
  endtask

  initial begin
    rst = 1;
    start = 0;
    dividend = 0;
    divisor = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dz", div_by_zero, 0);
    rst = 0;

    exp_q.push_back({4'd3, 4'd1, 1'b0});
    launch(4'd13, 4'd4);
    check("busy_after_accept", busy, 1);
    wait_done(cyc);
    check("latency_13_4", cyc, 4);
    check("busy_in_done", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    repeat (3) @(negedge clk);
    check("hold_q", quotient, 3);
    check("hold_r", remainder, 1);

    run(4'd15, 4'd1, {4'd15, 4'd0, 1'b0});
    run(4'd0, 4'd5, {4'd0, 4'd0, 1'b0});
    run(4'd7, 4'd9, {4'd0, 4'd7, 1'b0});
    run(4'd15, 4'd15, {4'd1, 4'd0, 1'b0});
    run(4'd9, 4'd0, {4'd15, 4'd9, 1'b1});
    check("latency_div0", cyc, 4);
    run(4'd8, 4'd2, {4'd4, 4'd0, 1'b0});

    exp_q.push_back({4'd2, 4'd2, 1'b0});
    launch(4'd12, 4'd5);
    @(negedge clk);
    start = 1;
    dividend = 3;
    divisor = 1;
    @(negedge clk);
    start = 0;
    wait_done(cyc);
    repeat (10) @(negedge clk);

    launch(4'd14, 4'd3);
    @(negedge clk);
    rst = 1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_q", quotient, 0);
    check("midrst_r", remainder, 0);
    check("midrst_dz", div_by_zero, 0);
    @(negedge clk);
    rst = 0;
    repeat (10) @(negedge clk);
    check("midrst_no_done_pending", exp_q.size(), 0);
    run(4'd14, 4'd3, {4'd4, 4'd2, 1'b0});

    @(negedge clk);
    exp_q.push_back({4'd3, 4'd1, 1'b0});
    start = 1;
    dividend = 10;
    divisor = 3;
    wait_done(cyc);
    exp_q.push_back({4'd5, 4'd1, 1'b0});
    dividend = 11;
    divisor = 2;
    wait_done(cyc);
    start = 0;
    check("b2b_gap", cyc, 5);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run(4'(a), 4'(b), model(4'(a), 4'(b)));

    repeat (10) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/int_div_core.md
# int_div_core

Sequential restoring integer divider that computes unsigned quotient and remainder one bit per clock. Sits directly upstream of the `tt_um_damor_rbz` top-level output pins. The top level feeds it `ui_in[7:4]` as the dividend and `ui_in[3:0]` as the divisor, and drives `uo_out = {quotient, remainder}`. A start/busy/done handshake lets the top level launch a division and capture the result.

## Interface

Parameters:
- `WIDTH`, default 4: operand and result width in bits; legal range 2..16.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  launch request; sampled only when `busy`=0.
- `dividend`  in  WIDTH  unsigned dividend; sampled on the accepting edge only.
- `divisor`  in  WIDTH  unsigned divisor; sampled on the accepting edge only.
- `busy`  out  1  high while an iteration is in progress.
- `done`  out  1  one-cycle pulse; results are valid from this cycle onward.
- `quotient`  out  WIDTH  registered quotient; held until the next completion.
- `remainder`  out  WIDTH  registered remainder; held until the next completion.
- `div_by_zero`  out  1  set with `done` when the accepted divisor was 0; held until the next completion.

## Operation

- States: IDLE, RUN.
- Internal registers:
  - D (WIDTH): latched divisor.
  - Q (WIDTH): dividend shifting out, quotient shifting in.
  - R (WIDTH+1): partial remainder.
  - cnt: ceil(log2(WIDTH+1)) bits.
  - dz: latched divide-by-zero flag.
- IDLE, `start`=1:
  - D←divisor, Q←dividend, R←0, cnt←WIDTH, dz←(divisor==0).
  - Go to RUN.
- IDLE, `start`=0: nothing changes.
- RUN, each edge performs one restoring step:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} − {1'b0, D}, computed in WIDTH+1 bits.
  - If T[WIDTH]==0: R←T, Q←{Q[WIDTH-2:0], 1}.
  - Else: R←{R[WIDTH-1:0], Q[WIDTH-1]}, Q←{Q[WIDTH-2:0], 0}.
  - cnt←cnt−1.
- RUN, on the edge where cnt==1 (the final step):
  - `quotient`←next Q, `remainder`←next R[WIDTH-1:0], `div_by_zero`←dz, `done`←1.
  - Go to IDLE.
- `done` is registered. It clears on the next edge unconditionally.
- `start` while `busy`=1 is ignored. No queuing, no effect on the operation in flight.
- Divisor 0 takes no special path. The algorithm naturally yields quotient = all ones and remainder = dividend; the flag only reports it.
- Operand inputs may change freely after the accepting edge.
- Reset, asserted at any time including mid-RUN:
  - State→IDLE; all internal registers→0.
  - `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0.
  - The in-flight operation is discarded. No `done` is produced for it.

## Timing

- `busy` is a combinational decode of state==RUN. It is high from the accepting edge until the completing edge.
- Latency: start accepted at edge k; `done` is high for exactly the cycle following edge k+WIDTH. Results update at that same edge k+WIDTH.
- `busy` is low during the `done` cycle. A `start` present in that cycle is accepted at edge k+WIDTH+1, giving back-to-back throughput of one division per WIDTH+1 cycles.
- Outputs change only at completion edges or on reset. Between completions they are stable.
- No combinational path exists from any input to any output.

## Test plan

- Reset, then `start` with dividend=13, divisor=4 (WIDTH=4): `busy` is high for 4 cycles; `done` pulses on cycle 5 counted from the accepting edge with quotient=3, remainder=1, div_by_zero=0; outputs hold afterwards.
- Corner operands, one at a time, each checked at `done`:
  - 15/1 → quotient 15, remainder 0.
  - 0/5 → quotient 0, remainder 0.
  - 7/9 → quotient 0, remainder 7.
  - 15/15 → quotient 1, remainder 0.
- Divisor 0, dividend 9: `done` after 4 cycles with quotient=15, remainder=9, div_by_zero=1. A following 8/2 clears the flag and gives quotient 4, remainder 0.
- Start while busy: launch 12/5, then pulse `start` with 3/1 on the 2nd busy cycle. Required: a single `done` with quotient 2, remainder 2; the 3/1 request is dropped.
- Reset mid-operation: launch 14/3, assert `rst` on the 2nd busy cycle. Required: all outputs read 0 immediately, and no `done` follows. After deassertion, 14/3 gives quotient 4, remainder 2.
- Back-to-back: hold `start`=1 continuously with operands 10/3, then 11/2 changed in the `done` cycle. Required: `done` pulses 5 cycles apart, with results 3/1 then 5/1.
- Exhaustive (WIDTH=4): all 256 operand pairs, checked against the reference model (q = a/b, r = a%b for b≠0; q=15, r=a for b=0).
